barrel_unshifter_seq: RTL and testbench

Iterative inverse of the 4-mode barrel shifter. It takes an already-shifted word plus the original shift amount and mode, and undoes the operation one bit position per clock. It returns the recovered word and a mask of which bits are genuinely recoverable; logical shifts destroy bits, rotates do not. It sits on the receive/decode side of any path that carries shifter output, with a valid/ready handshake on both sides.

---
 rtl/shifter_pkg.sv | 20 ++
 rtl/shift_step.sv | 25 ++
 rtl/barrel_unshifter_seq.sv | 100 ++++++++++
 tb/tb_barrel_unshifter_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Definitions shared by the forward barrel shifter and its iterative inverse:
// mode encodings and the unshifter state encoding.
package shifter_pkg;

   localparam logic [1:0] MODE_LSL = 2'b00;
   localparam logic [1:0] MODE_LSR = 2'b01;
   localparam logic [1:0] MODE_ROL = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic is_rotate(input logic [1:0] mode);
      return mode[1];
   endfunction

endpackage

// File: rtl/shift_step.sv
// One-position inverse step. The mode input is the forward mode, and the step
// moves the word in the opposite direction. fill_i feeds the vacated bit.
module shift_step
   import shifter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             fill_i,
   output logic [WIDTH-1:0] data_o
);

   always_comb begin
      data_o = data_i;
      case (mode_i)
         MODE_LSL: data_o = {fill_i, data_i[WIDTH-1:1]};
         MODE_LSR: data_o = {data_i[WIDTH-2:0], fill_i};
         MODE_ROL: data_o = {data_i[0], data_i[WIDTH-1:1]};
         MODE_ROR: data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
         default:  data_o = data_i;
      endcase
   end

endmodule

// File: rtl/barrel_unshifter_seq.sv
// Iterative inverse of the 4-mode barrel shifter: undoes one bit position per
// clock and reports which output bits are genuinely recoverable.
module barrel_unshifter_seq
   import shifter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int SHIFT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHIFT_W-1:0] shift,
   input  logic [1:0]         mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   data_out,
   output logic [WIDTH-1:0]   known_mask
);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [WIDTH-1:0]     mask_q, mask_d;
   logic [1:0]           mode_q, mode_d;
   logic [SHIFT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     step_data, step_mask;

   // Logical inverses zero-fill both data and mask; rotates ignore the fill.
   shift_step #(.WIDTH(WIDTH)) u_step_data (
      .mode_i (mode_q),
      .data_i (data_q),
      .fill_i (1'b0),
      .data_o (step_data)
   );

   shift_step #(.WIDTH(WIDTH)) u_step_mask (
      .mode_i (mode_q),
      .data_i (mask_q),
      .fill_i (1'b0),
      .data_o (step_mask)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         mask_q  <= '0;
         mode_q  <= MODE_LSL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      mask_d    = mask_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_d  = data_in;
               mask_d  = '1;
               mode_d  = mode;
               cnt_d   = shift;
               state_d = (shift != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            data_d = step_data;
            mask_d = is_rotate(mode_q) ? mask_q : step_mask;
            cnt_d  = cnt_q - SHIFT_W'(1);
            if (cnt_q == SHIFT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data_out   = data_q;
   assign known_mask = mask_q;

endmodule

// File: tb/tb_barrel_unshifter_seq.sv
// Directed bench for barrel_unshifter_seq with hand-computed expected results.
module tb_barrel_unshifter_seq;

   localparam int WIDTH   = 4;
   localparam int SHIFT_W = 2;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   data_in;
   logic [SHIFT_W-1:0] shift;
   logic [1:0]         mode;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   data_out;
   logic [WIDTH-1:0]   known_mask;

   int checks = 0;
   int errors = 0;

   barrel_unshifter_seq #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_in    (data_in),
      .shift      (shift),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .known_mask (known_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge; it is accepted on the next rising edge.
   task automatic accept(input logic [3:0] d, input logic [1:0] s, input logic [1:0] m, input string tag);
      @(negedge clk);
      check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      data_in  = d;
      shift    = s;
      mode     = m;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count rising edges after acceptance until out_valid, bounded.
   task automatic wait_done(input int exp_lat, input string tag);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic finish_req(input logic [3:0] ed, input logic [3:0] em, input string tag);
      check({tag, " data_out"}, 32'(data_out), 32'(ed));
      check({tag, " known_mask"}, 32'(known_mask), 32'(em));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run(input logic [3:0] d, input logic [1:0] s, input logic [1:0] m,
                      input logic [3:0] ed, input logic [3:0] em, input string tag);
      accept(d, s, m, tag);
      wait_done(int'(s), tag);
      finish_req(ed, em, tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      shift     = '0;
      mode      = 2'b00;
      repeat (3) @(negedge clk);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset data_out", 32'(data_out), 32'd0);
      check("reset known_mask", 32'(known_mask), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle out_valid", 32'(out_valid), 32'd0);

      run(4'b0100, 2'd1, 2'b00, 4'b0010, 4'b0111, "lsl1");
      run(4'b1000, 2'd2, 2'b00, 4'b0010, 4'b0011, "lsl2");
      run(4'b0110, 2'd3, 2'b00, 4'b0000, 4'b0001, "lsl3");
      run(4'b0101, 2'd1, 2'b01, 4'b1010, 4'b1110, "lsr1");
      run(4'b1001, 2'd3, 2'b01, 4'b1000, 4'b1000, "lsr3");
      run(4'b0101, 2'd1, 2'b10, 4'b1010, 4'b1111, "rol1");
      run(4'b0101, 2'd3, 2'b11, 4'b1010, 4'b1111, "ror3");
      run(4'b0011, 2'd1, 2'b11, 4'b0110, 4'b1111, "ror1");
      run(4'b1010, 2'd0, 2'b01, 4'b1010, 4'b1111, "zero_lsr");
      run(4'b1010, 2'd0, 2'b10, 4'b1010, 4'b1111, "zero_rol");

      // Busy inputs must be ignored; DONE must hold under backpressure.
      accept(4'b1011, 2'd2, 2'b10, "bp");
      data_in  = 4'b0000;
      shift    = 2'd1;
      mode     = 2'b01;
      in_valid = 1'b1;
      wait_done(2, "bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp out_valid held", 32'(out_valid), 32'd1);
         check("bp in_ready held", 32'(in_ready), 32'd0);
         check("bp data stable", 32'(data_out), 32'b1110);
         check("bp mask stable", 32'(known_mask), 32'b1111);
      end
      in_valid = 1'b0;
      finish_req(4'b1110, 4'b1111, "bp");

      // Asynchronous reset in the middle of a shift.
      accept(4'b1000, 2'd3, 2'b00, "rst");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst data_out", 32'(data_out), 32'd0);
      check("rst known_mask", 32'(known_mask), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run(4'b1000, 2'd3, 2'b00, 4'b0001, 4'b0001, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
